// File: rtl/mem_arb_pkg.sv
// Shared types and round-robin pick function for the two-requester RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } req_id_t;

  // With both requesters contending, ptr names the winner; otherwise the lone requester wins.
  function automatic req_id_t rr_pick(input logic valid_a, input logic valid_b, input req_id_t ptr);
    if (valid_a && valid_b) return ptr;
    else if (valid_a)       return ID_A;
    else                    return ID_B;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter; the pointer flips only on cycles where both requesters contend.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic    clock,
  input  logic    resetn,
  input  logic    req_a,
  input  logic    req_b,
  output logic    gnt,
  output req_id_t gnt_id
);

  req_id_t ptr;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ptr <= ID_A;
    end else if (req_a && req_b) begin
      ptr <= (ptr == ID_A) ? ID_B : ID_A;
    end
  end

  always_comb begin
    gnt    = req_a | req_b;
    gnt_id = rr_pick(req_a, req_b, ptr);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one simple dual-port RAM between requesters A and B with independent read/write round-robin.
// Optional same-cycle write-to-read forwarding is enabled with `define MEM_ARB_RAW_BYPASS_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  a_valid,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ready,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ready,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_wraddress,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_rdaddress,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  // Handshake: a request transfers when valid && ready; ready depends only on valid/we and arbiter state.
  logic    rd_req_a, rd_req_b, wr_req_a, wr_req_b;
  logic    rd_gnt, wr_gnt;
  req_id_t rd_id, wr_id;
  logic    rsp_v;
  req_id_t rsp_id;
  logic [DATA_WIDTH-1:0] rdata;

  // Gating requests with resetn keeps ready low and the pointers frozen during reset.
  assign rd_req_a = resetn && a_valid && !a_we;
  assign rd_req_b = resetn && b_valid && !b_we;
  assign wr_req_a = resetn && a_valid &&  a_we;
  assign wr_req_b = resetn && b_valid &&  b_we;

  rr_arb2 u_rd_arb (
    .clock  (clock),
    .resetn (resetn),
    .req_a  (rd_req_a),
    .req_b  (rd_req_b),
    .gnt    (rd_gnt),
    .gnt_id (rd_id)
  );

  rr_arb2 u_wr_arb (
    .clock  (clock),
    .resetn (resetn),
    .req_a  (wr_req_a),
    .req_b  (wr_req_b),
    .gnt    (wr_gnt),
    .gnt_id (wr_id)
  );

  always_comb begin
    a_ready       = (rd_gnt && rd_id == ID_A) || (wr_gnt && wr_id == ID_A);
    b_ready       = (rd_gnt && rd_id == ID_B) || (wr_gnt && wr_id == ID_B);
    ram_wren      = wr_gnt;
    ram_wraddress = (wr_id == ID_B) ? b_addr  : a_addr;
    ram_data      = (wr_id == ID_B) ? b_wdata : a_wdata;
    ram_rdaddress = (rd_gnt && rd_id == ID_B) ? b_addr : a_addr;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rsp_v  <= 1'b0;
      rsp_id <= ID_A;
    end else begin
      rsp_v  <= rd_gnt;
      rsp_id <= rd_id;
    end
  end

`ifdef MEM_ARB_RAW_BYPASS_EN
  logic                  byp_hit;
  logic [DATA_WIDTH-1:0] byp_data;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit  <= rd_gnt && wr_gnt && (ram_rdaddress == ram_wraddress);
      byp_data <= ram_data;
    end
  end

  assign rdata = byp_hit ? byp_data : ram_q;
`else
  assign rdata = ram_q;
`endif

  // A response whose handshake preceded a reset cycle is suppressed by the resetn term.
  assign a_rvalid = resetn && rsp_v && (rsp_id == ID_A);
  assign b_rvalid = resetn && rsp_v && (rsp_id == ID_B);
  assign a_rdata  = rdata;
  assign b_rdata  = rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a behavioural RAM and a queue-based response scoreboard.
module tb_mem_port_arbiter;

  logic       clock = 1'b0;
  logic       resetn;
  logic       a_valid, a_we, b_valid, b_we;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ready, a_rvalid, b_ready, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_wren;
  logic [3:0] ram_wraddress, ram_rdaddress;
  logic [7:0] ram_data, ram_q;

  int checks   = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  logic [7:0] mem[16];

  // clock / reset
  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clock(clock), .resetn(resetn),
    .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_wren(ram_wren), .ram_wraddress(ram_wraddress), .ram_data(ram_data),
    .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
  );

  // Behavioural simple dual-port RAM: registered read, old data on same-address write.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    ram_q = 8'h00;
  end
  always @(posedge clock) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    ram_q <= mem[ram_rdaddress];
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // scoreboard monitor: every response must match the oldest expected entry {id, data}
  always @(negedge clock) begin
    logic [8:0] e;
    if (a_rvalid && b_rvalid) check("rvalid_both", 16'd1, 16'd0);
    if (a_rvalid || b_rvalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", {7'd0, b_rvalid, b_rvalid ? b_rdata : a_rdata}, 16'hffff);
      end else begin
        e = exp_q.pop_front();
        check("rsp", {7'd0, b_rvalid, b_rvalid ? b_rdata : a_rdata}, {7'd0, e});
      end
    end
  end

  // driver: apply one cycle of requests, check handshake/RAM drive, queue expected read responses
  task automatic drive(input logic av, input logic awe, input logic [3:0] aaddr, input logic [7:0] awd,
                       input logic bv, input logic bwe, input logic [3:0] baddr, input logic [7:0] bwd,
                       input logic ear, input logic ebr, input logic ewren,
                       input logic [7:0] ard, input logic [7:0] brd, input logic push_en);
    a_valid = av; a_we = awe; a_addr = aaddr; a_wdata = awd;
    b_valid = bv; b_we = bwe; b_addr = baddr; b_wdata = bwd;
    @(negedge clock);
    check("a_ready", {15'd0, a_ready}, {15'd0, ear});
    check("b_ready", {15'd0, b_ready}, {15'd0, ebr});
    check("ram_wren", {15'd0, ram_wren}, {15'd0, ewren});
    if (ewren) begin
      check("ram_wraddress", {12'd0, ram_wraddress}, {12'd0, (ear && awe) ? aaddr : baddr});
      check("ram_data", {8'd0, ram_data}, {8'd0, (ear && awe) ? awd : bwd});
    end
    if (ear && !awe) check("ram_rdaddress", {12'd0, ram_rdaddress}, {12'd0, aaddr});
    else if (ebr && !bwe) check("ram_rdaddress", {12'd0, ram_rdaddress}, {12'd0, baddr});
    if (push_en && ear && !awe) exp_q.push_back({1'b0, ard});
    if (push_en && ebr && !bwe) exp_q.push_back({1'b1, brd});
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] raw_exp;
`ifdef MEM_ARB_RAW_BYPASS_EN
    raw_exp = 8'hF0;
`else
    raw_exp = 8'h0F;
`endif
    resetn = 1'b0;
    a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    @(posedge clock); #1;
    // reset holds ready and wren low even with valid requests
    drive(1, 0, 4'h1, 8'h00, 1, 1, 4'h2, 8'h99, 0, 0, 0, 8'h00, 8'h00, 1);
    drive(1, 1, 4'h1, 8'h77, 1, 0, 4'h2, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1);
    resetn = 1'b1;

    // single write then read
    drive(1, 1, 4'h3, 8'h5A, 0, 0, 4'h0, 8'h00, 1, 0, 1, 8'h00, 8'h00, 1);
    drive(1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00, 1, 0, 0, 8'h5A, 8'h00, 1);
    idle();

    // read contention: grants alternate A,B,A,B
    drive(1, 1, 4'h1, 8'h01, 0, 0, 4'h0, 8'h00, 1, 0, 1, 8'h00, 8'h00, 1);
    drive(0, 0, 4'h0, 8'h00, 1, 1, 4'h2, 8'h02, 0, 1, 1, 8'h00, 8'h00, 1);
    drive(1, 0, 4'h1, 8'h00, 1, 0, 4'h2, 8'h00, 1, 0, 0, 8'h01, 8'h00, 1);
    drive(1, 0, 4'h1, 8'h00, 1, 0, 4'h2, 8'h00, 0, 1, 0, 8'h00, 8'h02, 1);
    drive(1, 0, 4'h1, 8'h00, 1, 0, 4'h2, 8'h00, 1, 0, 0, 8'h01, 8'h00, 1);
    drive(1, 0, 4'h1, 8'h00, 1, 0, 4'h2, 8'h00, 0, 1, 0, 8'h00, 8'h02, 1);
    idle();

    // read/write concurrency
    drive(1, 1, 4'h4, 8'h11, 0, 0, 4'h0, 8'h00, 1, 0, 1, 8'h00, 8'h00, 1);
    drive(1, 0, 4'h4, 8'h00, 1, 1, 4'h5, 8'h22, 1, 1, 1, 8'h11, 8'h00, 1);
    drive(0, 0, 4'h0, 8'h00, 1, 0, 4'h5, 8'h00, 0, 1, 0, 8'h00, 8'h22, 1);
    idle();

    // same-cycle same-address write and read
    drive(0, 0, 4'h0, 8'h00, 1, 1, 4'h7, 8'h0F, 0, 1, 1, 8'h00, 8'h00, 1);
    drive(1, 0, 4'h7, 8'h00, 1, 1, 4'h7, 8'hF0, 1, 1, 1, raw_exp, 8'h00, 1);
    drive(1, 0, 4'h7, 8'h00, 0, 0, 4'h0, 8'h00, 1, 0, 0, 8'hF0, 8'h00, 1);
    idle();

    // write contention: A first, B retries; then pointer favours B
    drive(1, 1, 4'h0, 8'hAA, 1, 1, 4'h0, 8'hBB, 1, 0, 1, 8'h00, 8'h00, 1);
    drive(0, 0, 4'h0, 8'h00, 1, 1, 4'h0, 8'hBB, 0, 1, 1, 8'h00, 8'h00, 1);
    drive(1, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 0, 0, 8'hBB, 8'h00, 1);
    drive(1, 1, 4'h8, 8'h33, 1, 1, 4'h8, 8'h44, 0, 1, 1, 8'h00, 8'h00, 1);
    drive(1, 1, 4'h8, 8'h33, 0, 0, 4'h0, 8'h00, 1, 0, 1, 8'h00, 8'h00, 1);
    drive(0, 0, 4'h0, 8'h00, 1, 0, 4'h8, 8'h00, 0, 1, 0, 8'h00, 8'h33, 1);
    idle();

    // reset mid-operation: move rd_ptr to B, then a lone A read right before reset
    drive(1, 0, 4'h3, 8'h00, 1, 0, 4'h2, 8'h00, 1, 0, 0, 8'h5A, 8'h00, 1);
    drive(1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0);
    resetn = 1'b0;
    drive(1, 1, 4'h9, 8'h55, 1, 0, 4'h2, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1);
    drive(1, 0, 4'h3, 8'h00, 1, 1, 4'h9, 8'h66, 0, 0, 0, 8'h00, 8'h00, 1);
    resetn = 1'b1;
    drive(1, 0, 4'h3, 8'h00, 1, 0, 4'h2, 8'h00, 1, 0, 0, 8'h5A, 8'h00, 1);
    drive(0, 0, 4'h0, 8'h00, 1, 0, 4'h9, 8'h00, 0, 1, 0, 8'h00, 8'h00, 1);
    idle();
    idle();

    check("exp_q_drained", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one simple dual-port RAM (one write port, one read port, registered read with 1-cycle latency, reads old data on a same-cycle same-address write) between two requesters, A and B.
- Each requester issues at most one read or one write per cycle using a valid/ready handshake.
- Reads and writes are arbitrated independently with round-robin. Read data returns one cycle after grant, tagged to the issuing requester.
- Sits between the CPU's load/store and fetch/refill agents and the RAM instance.

Parameters:
- ADDR_WIDTH, 4, RAM address width; must match the RAM.
- DATA_WIDTH, 8, RAM data width; must match the RAM.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- a_valid  in  1  requester A has a request.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  request address.
- a_wdata  in  DATA_WIDTH  write data.
- a_ready  out  1  A's request is accepted this cycle.
- a_rvalid  out  1  read data for A valid this cycle.
- a_rdata  out  DATA_WIDTH  read data for A.
- b_valid, b_we, b_addr, b_wdata, b_ready, b_rvalid, b_rdata: same as the A ports, for requester B.
- ram_wren  out  1  to RAM wren.
- ram_wraddress  out  ADDR_WIDTH  to RAM wraddress.
- ram_data  out  DATA_WIDTH  to RAM data.
- ram_rdaddress  out  ADDR_WIDTH  to RAM rdaddress.
- ram_q  in  DATA_WIDTH  from RAM q.

Behaviour:
- Handshake:
  - A request transfers when valid && ready in the same cycle.
  - The requester holds we/addr/wdata stable while valid && !ready.
  - ready is combinational from valid/we and the arbiter state. ready is never asserted without valid.
- Read arbitration:
  - Read candidates are the requesters with valid && !we.
  - With one candidate, it is granted.
  - With two candidates, the one selected by rd_ptr is granted (0 = A, 1 = B).
  - rd_ptr toggles only on a cycle where both requesters were candidates.
- Write arbitration: same rule with wr_ptr over valid && we candidates.
- Concurrency:
  - A read grant and a write grant may occur in the same cycle, e.g. A reads while B writes; both ready are high.
  - The loser of a contended port sees ready low and retries the next cycle.
- RAM drive:
  - ram_wren = write granted; ram_wraddress and ram_data come from the write winner.
  - ram_rdaddress comes from the read winner, or from A when there is no read grant (don't-care).
  - These outputs are combinational.
- Response pipeline:
  - Registers rsp_v (1 bit) and rsp_id (1 bit) capture read grant and winner at the clock edge.
  - Next cycle: a_rvalid = rsp_v && rsp_id==0, b_rvalid = rsp_v && rsp_id==1.
  - a_rdata = b_rdata = ram_q (or the bypass data, see Optional Feature).
  - Read latency is exactly 1 cycle after the handshake. There is no backpressure on responses.
  - Back-to-back reads sustain 1 read per cycle total.
- Hazards:
  - Write at cycle t followed by a read of the same address at t+1 or later returns the new data.
  - Same-cycle write and read to the same address returns old data unless the bypass is enabled.
- Reset (resetn low at a rising edge):
  - rd_ptr = 0, wr_ptr = 0, rsp_v = 0.
  - While resetn is low, ready is forced to 0 and ram_wren = 0.
  - A read accepted the cycle before reset asserts yields no rvalid.
- Idle: with no valid, all ready = 0, ram_wren = 0, and the pointers hold.

Optional Feature:
- Macro: MEM_ARB_RAW_BYPASS_EN.
- Defined:
  - When the read grant and write grant in the same cycle have equal addresses, the write data is registered into byp_data and byp_hit = 1.
  - The next cycle, rdata = byp_data instead of ram_q.
  - byp_hit resets to 0.
- Undefined: rdata = ram_q always (old-value semantics), and no bypass registers exist.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef req_id_t (1 bit; ID_A = 0, ID_B = 1).
  - Function rr_pick(valid_a, valid_b, ptr) returning the granted id.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter with pointer register. It is instantiated twice (read, write).

Test Plan:
- Single read: after reset, write 0x5A to addr 3 via A, then A reads addr 3 -> a_ready=1 on both handshakes; a_rvalid=1 with a_rdata=0x5A exactly 1 cycle after the read handshake, b_rvalid=0.
- Read contention: A and B both read (addr 1, addr 2) for 4 consecutive cycles, holding valid -> grants alternate A,B,A,B; rvalid alternates a,b one cycle later; rd_ptr starts at A after reset.
- Read/write concurrency: A reads addr 4 (holding 0x11) while B writes 0x22 to addr 5 -> both ready=1 in the same cycle; a_rdata=0x11; a later read of addr 5 returns 0x22.
- Same-address RAW: addr 7 holds 0x0F; B writes 0xF0 to addr 7 while A reads addr 7 -> a_rdata=0x0F without MEM_ARB_RAW_BYPASS_EN, 0xF0 with it.
- Write contention: A and B both write addr 0 (0xAA, 0xBB) -> A granted first, B next cycle; a final read of addr 0 returns 0xBB.
- Reset mid-operation: A read handshake at cycle t, resetn=0 at t+1 -> no a_rvalid at t+1; ready=0 and ram_wren=0 while reset is held; after release, the pointers favour A.
